mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the fetch stage and the memory stage of the pipelined core.
- Sequences each access as request, grant and read-data return. Drives stall_f and stall_m so the fetch and EX/MEM pipeline registers hold until their access completes.
- Sits between the memory-stage control and data signals (read, write, address, write data) and the external memory port.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the fetch stage and the memory
//   stage. Each access is sequenced as request -> grant -> (read data) -> done.
//   The stall outputs hold the requesting pipeline stage until its done cycle.
//   When both stages request at once, data wins unless the previous completed
//   access was a data access.
//
//   Optional feature: define ARB_TIMEOUT_EN to abort any access that spends
//   TIMEOUT cycles in its request/wait phase. An aborted access still finishes
//   through its DONE state, with that port's read data forced to 0, and sets a
//   sticky timeout_err. When the macro is undefined, timeout_err is tied to 0.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   if_req/if_addr          fetch request and address
//   if_rdata/if_done        fetched word (registered) and completion pulse
//   dm_rd/dm_wr/dm_addr/dm_wdata  memory-stage load/store request
//   dm_rdata/dm_done        load data (registered) and completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  external memory request (registered)
//   mem_gnt/mem_rvalid/mem_rdata       external memory grant and read return
//   stall_f/stall_m         stage hold signals
//   timeout_err             sticky access-timeout flag
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_done,
  input  logic             dm_rd,
  input  logic             dm_wr,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             dm_done,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall_f,
  output logic             stall_m,
  output logic             timeout_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_D_REQ  = 3'd1;
  localparam logic [2:0] S_D_WAIT = 3'd2;
  localparam logic [2:0] S_D_DONE = 3'd3;
  localparam logic [2:0] S_F_REQ  = 3'd4;
  localparam logic [2:0] S_F_WAIT = 3'd5;
  localparam logic [2:0] S_F_DONE = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_last_data;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [WIDTH-1:0] r_dm_rdata;
  logic [WIDTH-1:0] r_if_rdata;

  logic w_dm_any;
  logic w_fetch_favoured;
  logic w_in_req;
  logic w_in_wait;
  logic w_progress;
  logic w_tmo;
  logic w_tmo_fire;

  assign w_dm_any         = dm_rd | dm_wr;
  assign w_fetch_favoured = r_last_data & if_req;
  assign w_in_req         = (r_state == S_D_REQ) || (r_state == S_F_REQ);
  assign w_in_wait        = (r_state == S_D_WAIT) || (r_state == S_F_WAIT);
  assign w_progress       = (w_in_req & mem_gnt) | (w_in_wait & mem_rvalid);
  // A timeout only takes effect when the memory did not respond that cycle.
  assign w_tmo_fire       = w_tmo & ~w_progress;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_tmo_cnt;
  logic          r_timeout_err;

  assign w_tmo       = (w_in_req | w_in_wait) && (r_tmo_cnt == CW'(TIMEOUT - 1));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_tmo_cnt <= '0;
      else if (w_in_req | w_in_wait)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_tmo_fire)
        r_timeout_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_tmo            = 1'b0;
  assign timeout_err      = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dm_any && !w_fetch_favoured) w_next = S_D_REQ;
        else if (if_req)                   w_next = S_F_REQ;
      end
      S_D_REQ: begin
        if (mem_gnt)    w_next = r_mem_we ? S_D_DONE : S_D_WAIT;
        else if (w_tmo) w_next = S_D_DONE;
      end
      S_D_WAIT: if (mem_rvalid || w_tmo) w_next = S_D_DONE;
      S_D_DONE: w_next = S_IDLE;
      S_F_REQ: begin
        if (mem_gnt)    w_next = S_F_WAIT;
        else if (w_tmo) w_next = S_F_DONE;
      end
      S_F_WAIT: if (mem_rvalid || w_tmo) w_next = S_F_DONE;
      S_F_DONE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_data <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dm_rdata  <= '0;
      r_if_rdata  <= '0;
    end else begin
      r_state   <= w_next;
      r_mem_req <= (w_next == S_D_REQ) || (w_next == S_F_REQ);

      // Request fields are captured only on entry so they stay stable even if
      // the stage changes its inputs while the access is in flight.
      if (r_state == S_IDLE && w_next == S_D_REQ) begin
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
        r_mem_we    <= dm_wr;
      end else if (r_state == S_IDLE && w_next == S_F_REQ) begin
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
        r_mem_we    <= 1'b0;
      end

      if (r_state == S_D_WAIT && mem_rvalid)
        r_dm_rdata <= mem_rdata;
      else if (w_tmo_fire && (r_state == S_D_REQ || r_state == S_D_WAIT))
        r_dm_rdata <= '0;

      if (r_state == S_F_WAIT && mem_rvalid)
        r_if_rdata <= mem_rdata;
      else if (w_tmo_fire && (r_state == S_F_REQ || r_state == S_F_WAIT))
        r_if_rdata <= '0;

      if (r_state == S_D_DONE)
        r_last_data <= 1'b1;
      else if (r_state == S_F_DONE)
        r_last_data <= 1'b0;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_rdata  = r_if_rdata;
  assign dm_done   = (r_state == S_D_DONE);
  assign if_done   = (r_state == S_F_DONE);
  assign stall_m   = w_dm_any && (r_state != S_D_DONE);
  assign stall_f   = if_req && (r_state != S_F_DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized
// transaction run checked against a cycle-schedule reference model.
module tb_mem_port_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic [W-1:0] if_rdata;
  logic         if_done;
  logic         dm_rd;
  logic         dm_wr;
  logic [W-1:0] dm_addr;
  logic [W-1:0] dm_wdata;
  logic [W-1:0] dm_rdata;
  logic         dm_done;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [W-1:0] mem_rdata;
  logic         stall_f;
  logic         stall_m;
  logic         timeout_err;

  int total = 0;
  int bad   = 0;

  // Reference state derived from the arbitration rules.
  logic         m_last_data;
  logic [W-1:0] m_dm_rdata;
  logic [W-1:0] m_if_rdata;

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled at
  // the following falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [4*W+6:0] outs;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    outs = {mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata,
            if_done, dm_done, stall_f, stall_m, timeout_err};
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    next_cycle();
    reset = 1'b0;
    m_last_data = 1'b0; m_dm_rdata = '0; m_if_rdata = '0;
  endtask

  task automatic test_load();
    dm_rd = 1'b1; dm_addr = 32'h40;
    @(negedge clk);
    total++;
    if ({stall_m, mem_req, dm_done} !== 3'b100) begin
      bad++; $display("FAIL load_c0: got stall_m/req/done=%b want 100", {stall_m, mem_req, dm_done});
    end
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr, stall_m} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
      bad++; $display("FAIL load_c1: got req=%b we=%b addr=%h stall_m=%b want 1 0 40 1", mem_req, mem_we, mem_addr, stall_m);
    end
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    total++;
    if ({mem_req, stall_m, dm_done} !== 3'b010) begin
      bad++; $display("FAIL load_c2: got req/stall_m/done=%b want 010", {mem_req, stall_m, dm_done});
    end
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    total++;
    if ({dm_done, stall_m, dm_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      bad++; $display("FAIL load_c3: got done=%b stall_m=%b rdata=%h want 1 0 12345678", dm_done, stall_m, dm_rdata);
    end
    next_cycle();
    dm_rd = 1'b0;
    @(negedge clk);
    total++;
    if (dm_done !== 1'b0) begin
      bad++; $display("FAIL load_pulse: got dm_done=%b want 0", dm_done);
    end
    m_last_data = 1'b1; m_dm_rdata = 32'h12345678;
  endtask

  task automatic test_store();
    dm_wr = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hCAFEF00D;
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      mem_gnt = (c == 3);
      @(negedge clk);
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, dm_done} !== {1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 1'b0}) begin
        bad++; $display("FAIL store_c%0d: got req=%b we=%b addr=%h wdata=%h done=%b want 1 1 100 cafef00d 0", c, mem_req, mem_we, mem_addr, mem_wdata, dm_done);
      end
      next_cycle();
    end
    mem_gnt = 1'b0;
    @(negedge clk);
    total++;
    if ({dm_done, mem_req, stall_m} !== 3'b100) begin
      bad++; $display("FAIL store_c4: got done/req/stall_m=%b want 100", {dm_done, mem_req, stall_m});
    end
    next_cycle();
    dm_wr = 1'b0;
    m_last_data = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [4*W+6:0] outs;
    dm_rd = 1'b1; dm_addr = 32'h80;
    next_cycle();
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    // Now in the data wait phase; flush the stage and assert reset.
    reset = 1'b1; dm_rd = 1'b0;
    #1;
    outs = {mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata,
            if_done, dm_done, stall_f, stall_m, timeout_err};
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: got %h want 0", outs);
    end
    next_cycle();
    reset = 1'b0;
    m_last_data = 1'b0; m_dm_rdata = '0; m_if_rdata = '0;
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({dm_done, mem_req, dm_rdata} !== {1'b0, 1'b0, 32'h0}) begin
        bad++; $display("FAIL stale_rvalid_c%0d: got done=%b req=%b rdata=%h want 0 0 0", c, dm_done, mem_req, dm_rdata);
      end
      next_cycle();
      mem_rvalid = 1'b0; mem_rdata = '0;
    end
  endtask

  task automatic test_contention();
    dm_rd = 1'b1; dm_addr = 32'h200; if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    total++;
    if ({stall_m, stall_f} !== 2'b11) begin
      bad++; $display("FAIL cont_c0_stalls: got %b want 11", {stall_m, stall_f});
    end
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
      bad++; $display("FAIL cont_data_first: got req=%b we=%b addr=%h want 1 0 200", mem_req, mem_we, mem_addr);
    end
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    next_cycle();
    mem_rvalid = 1'b0;
    dm_addr = 32'h204;  // stage immediately issues another load
    @(negedge clk);
    total++;
    if ({dm_done, if_done, stall_m, stall_f, dm_rdata} !== {1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA5555}) begin
      bad++; $display("FAIL cont_c3: got dd=%b fd=%b sm=%b sf=%b rdata=%h want 1 0 0 1 aaaa5555", dm_done, if_done, stall_m, stall_f, dm_rdata);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({stall_m, mem_req} !== 2'b10) begin
      bad++; $display("FAIL cont_c4: got stall_m/req=%b want 10", {stall_m, mem_req});
    end
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h300}) begin
      bad++; $display("FAIL cont_fetch_favoured: got req=%b we=%b addr=%h want 1 0 300", mem_req, mem_we, mem_addr);
    end
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13572468;
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({if_done, dm_done, stall_f, if_rdata} !== {1'b1, 1'b0, 1'b0, 32'h13572468}) begin
      bad++; $display("FAIL cont_fetch_done: got fd=%b dd=%b sf=%b rdata=%h want 1 0 0 13572468", if_done, dm_done, stall_f, if_rdata);
    end
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h204}) begin
      bad++; $display("FAIL cont_data_second: got req=%b addr=%h want 1 204", mem_req, mem_addr);
    end
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2468ACE0;
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({dm_done, dm_rdata} !== {1'b1, 32'h2468ACE0}) begin
      bad++; $display("FAIL cont_data_done: got done=%b rdata=%h want 1 2468ace0", dm_done, dm_rdata);
    end
    next_cycle();
    dm_rd = 1'b0;
    m_last_data = 1'b1; m_dm_rdata = 32'h2468ACE0; m_if_rdata = 32'h13572468;
  endtask

  // Each transaction: a data access, a fetch, or both at once. The model lays
  // out the cycle schedule of every access from the rules: request phase
  // starts the cycle after the IDLE cycle, grant after gd extra cycles, read
  // data rd cycles after that, done one cycle later.
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind, n_acc, end_t, dd, df;
      bit has_d, has_f, d_we, d_both, data_first;
      bit a_data[2], a_we[2];
      logic [W-1:0] a_addr[2], a_rdat[2];
      logic [W-1:0] d_addr, d_wdata, f_addr;
      int s[2], g[2], v[2], d[2];

      kind   = $urandom_range(0, 3);
      has_d  = (kind != 2);
      has_f  = (kind >= 2);
      d_we   = $urandom_range(0, 1);
      d_both = d_we && ($urandom_range(0, 1) == 1);
      d_addr = $urandom; d_wdata = $urandom; f_addr = $urandom;
      data_first = has_d && !(has_f && m_last_data);

      n_acc = 0;
      if (has_d && data_first) begin
        a_data[n_acc] = 1; a_we[n_acc] = d_we; a_addr[n_acc] = d_addr; n_acc++;
      end
      if (has_f) begin
        a_data[n_acc] = 0; a_we[n_acc] = 0; a_addr[n_acc] = f_addr; n_acc++;
      end
      if (has_d && !data_first) begin
        a_data[n_acc] = 1; a_we[n_acc] = d_we; a_addr[n_acc] = d_addr; n_acc++;
      end

      dd = -1; df = -1;
      for (int k = 0; k < n_acc; k++) begin
        s[k] = (k == 0) ? 0 : d[k-1] + 1;
        g[k] = s[k] + 1 + $urandom_range(0, 3);
        a_rdat[k] = $urandom;
        if (a_we[k]) begin
          v[k] = -1; d[k] = g[k] + 1;
        end else begin
          v[k] = g[k] + 1 + $urandom_range(0, 2); d[k] = v[k] + 1;
        end
        if (a_data[k]) dd = d[k]; else df = d[k];
      end
      end_t = d[n_acc-1];

      for (int t = 0; t <= end_t; t++) begin
        bit exp_req;
        int rk;
        dm_addr = d_addr; dm_wdata = d_wdata; if_addr = f_addr;
        dm_wr  = has_d && (t <= dd) && d_we;
        dm_rd  = has_d && (t <= dd) && (!d_we || d_both);
        if_req = has_f && (t <= df);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        exp_req = 0; rk = 0;
        for (int k = 0; k < n_acc; k++) begin
          if (t == g[k]) mem_gnt = 1'b1;
          if (t == v[k]) begin mem_rvalid = 1'b1; mem_rdata = a_rdat[k]; end
          // Responses that arrive outside their phase must be ignored.
          if (t >= s[k] && t < g[k] && $urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
          if ((t > g[k] && t < v[k]) || t == d[k])
            if ($urandom_range(0, 3) == 0) mem_gnt = 1'b1;
          if (t > s[k] && t <= g[k]) begin exp_req = 1; rk = k; end
        end
        @(negedge clk);
        if (t == dd && !d_we) begin
          for (int k = 0; k < n_acc; k++) if (a_data[k]) m_dm_rdata = a_rdat[k];
        end
        if (t == df) begin
          for (int k = 0; k < n_acc; k++) if (!a_data[k]) m_if_rdata = a_rdat[k];
        end
        total++;
        if (mem_req !== exp_req) begin
          bad++; $display("FAIL rnd%0d_t%0d mem_req: got %b want %b", n, t, mem_req, exp_req);
        end
        if (exp_req) begin
          total++;
          if ({mem_we, mem_addr} !== {a_we[rk], a_addr[rk]} || (a_we[rk] && mem_wdata !== d_wdata)) begin
            bad++; $display("FAIL rnd%0d_t%0d req_fields: got we=%b addr=%h wdata=%h want we=%b addr=%h", n, t, mem_we, mem_addr, mem_wdata, a_we[rk], a_addr[rk]);
          end
        end
        total++;
        if ({dm_done, if_done} !== {(t == dd), (t == df)}) begin
          bad++; $display("FAIL rnd%0d_t%0d done: got dd=%b fd=%b want %b %b", n, t, dm_done, if_done, (t == dd), (t == df));
        end
        total++;
        if ({stall_m, stall_f} !== {(has_d && t < dd), (has_f && t < df)}) begin
          bad++; $display("FAIL rnd%0d_t%0d stall: got sm=%b sf=%b want %b %b", n, t, stall_m, stall_f, (has_d && t < dd), (has_f && t < df));
        end
        total++;
        if ({dm_rdata, if_rdata} !== {m_dm_rdata, m_if_rdata}) begin
          bad++; $display("FAIL rnd%0d_t%0d rdata: got d=%h f=%h want d=%h f=%h", n, t, dm_rdata, if_rdata, m_dm_rdata, m_if_rdata);
        end
        if (t == dd) m_last_data = 1'b1;
        if (t == df) m_last_data = 1'b0;
        next_cycle();
      end
      clear_inputs();
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    dm_rd = 1'b1; dm_addr = 32'h44;
    next_cycle();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if ({mem_req, dm_done} !== 2'b10) begin
        bad++; $display("FAIL tmo_req_c%0d: got req/done=%b want 10", c, {mem_req, dm_done});
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if ({dm_done, mem_req, timeout_err, dm_rdata} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      bad++; $display("FAIL tmo_done: got done=%b req=%b err=%b rdata=%h want 1 0 1 0", dm_done, mem_req, timeout_err, dm_rdata);
    end
    next_cycle();
    dm_rd = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err);
    end
    next_cycle();
    reset = 1'b1;
    #1;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL tmo_reset: got %b want 0", timeout_err);
    end
    next_cycle();
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_reset_mid();
    test_contention();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
